// File: rtl/port_bridge_pkg.sv
// Shared constants for the CPU port bridge: port word width and default FIFO depth.
package port_bridge_pkg;
  localparam int PORT_W     = 16;
  localparam int FIFO_DEPTH = 4;

  typedef logic [PORT_W-1:0] port_word_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and combinational head read.
// PUSH_ON_FULL_POP lets a push land on a full FIFO when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH            = 16,
  parameter int DEPTH            = 4,
  parameter bit PUSH_ON_FULL_POP = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == DEPTH_C);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || (PUSH_ON_FULL_POP && w_do_pop));

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/port_bridge.sv
// Device-side endpoint of the CPU I/O ports: input FIFO feeding in_port, output FIFO
// capturing OUT write-backs, plus sticky overflow/underflow flags.
module port_bridge
  import port_bridge_pkg::*;
#(
  parameter int WIDTH = PORT_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] in_port,
  input  logic             in_ack,
  output logic             in_empty,
  input  logic [WIDTH-1:0] out_port,
  input  logic             out_strobe,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             ovf,
  output logic             udf,
  input  logic             clr_err
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] w_in_rdata;
  logic [CW-1:0]    w_in_count;
  logic             w_in_full;
  logic             w_in_empty;
  logic             w_in_push;
  logic             w_in_pop;
  logic [WIDTH-1:0] w_out_rdata;
  logic [CW-1:0]    w_out_count;
  logic             w_out_full;
  logic             w_out_empty;
  logic             w_out_pop;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic             r_ovf;
  logic             r_udf;

  // Input side: no push-through on full, so s_ready ignores in_ack.
  assign s_ready   = rst && !w_in_full;
  assign w_in_push = s_valid && s_ready;
  assign w_in_pop  = rst && in_ack && !w_in_empty;
  assign in_empty  = !rst || w_in_empty;
  assign in_port   = (rst && !w_in_empty) ? w_in_rdata : '0;
  assign w_udf_evt = rst && in_ack && (w_in_count == '0);

  sync_fifo #(
    .WIDTH            (WIDTH),
    .DEPTH            (DEPTH),
    .PUSH_ON_FULL_POP (1'b0)
  ) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_in_push),
    .pop   (w_in_pop),
    .wdata (s_data),
    .rdata (w_in_rdata),
    .count (w_in_count),
    .full  (w_in_full),
    .empty (w_in_empty)
  );

  // Output side: the CPU is never stalled; a strobe on a full FIFO only drops if no pop frees a slot.
  assign m_valid   = rst && (w_out_count != '0);
  assign m_data    = (rst && !w_out_empty) ? w_out_rdata : '0;
  assign w_out_pop = m_valid && m_ready;
  assign w_ovf_evt = rst && out_strobe && w_out_full && !m_ready;

  sync_fifo #(
    .WIDTH            (WIDTH),
    .DEPTH            (DEPTH),
    .PUSH_ON_FULL_POP (1'b1)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_strobe),
    .pop   (w_out_pop),
    .wdata (out_port),
    .rdata (w_out_rdata),
    .count (w_out_count),
    .full  (w_out_full),
    .empty (w_out_empty)
  );

  // Sticky error flags; a fresh event outranks clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
      if (w_udf_evt) begin
        r_udf <= 1'b1;
      end else if (clr_err) begin
        r_udf <= 1'b0;
      end else begin
        r_udf <= r_udf;
      end
    end
  end

  assign ovf = r_ovf;
  assign udf = r_udf;
endmodule

// File: tb/tb_port_bridge.sv
// Self-checking bench for port_bridge: directed steps plus a random wrap stream,
// with per-direction expected-word queues as the scoreboard.
module tb_port_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] s_data = 16'h0000;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] in_port;
  logic        in_ack = 1'b0;
  logic        in_empty;
  logic [15:0] out_port = 16'h0000;
  logic        out_strobe = 1'b0;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        ovf;
  logic        udf;
  logic        clr_err = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] in_q[$];
  logic [15:0] out_q[$];
  logic        ovf_m = 1'b0;
  logic        udf_m = 1'b0;
  int          in_acc = 0, in_got = 0, out_acc = 0, out_got = 0;
  logic [15:0] exp_a[4];
  logic [15:0] exp_b[4];

  port_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .in_port    (in_port),
    .in_ack     (in_ack),
    .in_empty   (in_empty),
    .out_port   (out_port),
    .out_strobe (out_strobe),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .ovf        (ovf),
    .udf        (udf),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("s_ready",  {15'd0, s_ready},  {15'd0, (in_q.size() < 4)});
    chk("in_empty", {15'd0, in_empty}, {15'd0, (in_q.size() == 0)});
    chk("in_port",  in_port, (in_q.size() != 0) ? in_q[0] : 16'h0000);
    chk("m_valid",  {15'd0, m_valid},  {15'd0, (out_q.size() != 0)});
    chk("m_data",   m_data, (out_q.size() != 0) ? out_q[0] : 16'h0000);
    chk("ovf",      {15'd0, ovf}, {15'd0, ovf_m});
    chk("udf",      {15'd0, udf}, {15'd0, udf_m});
  endtask

  task automatic cyc(input logic sv, input logic [15:0] sd, input logic ia,
                     input logic os, input logic [15:0] od, input logic mr, input logic ce);
    logic in_rdy, in_has, out_has, out_full;
    s_valid = sv; s_data = sd; in_ack = ia;
    out_strobe = os; out_port = od; m_ready = mr; clr_err = ce;
    #3;
    check_outs();
    in_rdy   = in_q.size() < 4;
    in_has   = in_q.size() != 0;
    out_has  = out_q.size() != 0;
    out_full = out_q.size() == 4;
    if (ia && in_has) begin void'(in_q.pop_front()); in_got++; end
    if (sv && in_rdy) begin in_q.push_back(sd); in_acc++; end
    if (mr && out_has) begin void'(out_q.pop_front()); out_got++; end
    if (os && (!out_full || mr)) begin out_q.push_back(od); out_acc++; end
    udf_m = (ia && !in_has) ? 1'b1 : (ce ? 1'b0 : udf_m);
    ovf_m = (os && out_full && !mr) ? 1'b1 : (ce ? 1'b0 : ovf_m);
    @(posedge clk); #1;
  endtask

  task automatic rst_cyc(input bit chk_flags, input logic busy);
    rst = 1'b0;
    s_valid = busy; s_data = 16'hDEAD; in_ack = busy;
    out_strobe = busy; out_port = 16'hFACE; m_ready = busy; clr_err = 1'b0;
    #3;
    chk("rst_s_ready",  {15'd0, s_ready},  16'h0000);
    chk("rst_m_valid",  {15'd0, m_valid},  16'h0000);
    chk("rst_in_empty", {15'd0, in_empty}, 16'h0001);
    chk("rst_in_port",  in_port, 16'h0000);
    chk("rst_m_data",   m_data,  16'h0000);
    if (chk_flags) begin
      chk("rst_ovf", {15'd0, ovf}, {15'd0, ovf_m});
      chk("rst_udf", {15'd0, udf}, {15'd0, udf_m});
    end
    @(posedge clk); #1;
    in_q.delete(); out_q.delete();
    ovf_m = 1'b0; udf_m = 1'b0;
    rst = 1'b1;
    s_valid = 1'b0; in_ack = 1'b0; out_strobe = 1'b0; m_ready = 1'b0;
  endtask

  initial begin
    exp_a[0] = 16'hA001; exp_a[1] = 16'hA002; exp_a[2] = 16'hA003; exp_a[3] = 16'hA004;
    exp_b[0] = 16'hA002; exp_b[1] = 16'hA003; exp_b[2] = 16'hA004; exp_b[3] = 16'hBEEF;

    // Reset held two cycles with stimulus active
    rst_cyc(1'b0, 1'b1);
    rst = 1'b0;
    rst_cyc(1'b1, 1'b1);
    cyc(0, 16'h0, 0, 0, 16'h0, 0, 0);
    chk("post_rst_s_ready",  {15'd0, s_ready},  16'h0001);
    chk("post_rst_in_empty", {15'd0, in_empty}, 16'h0001);

    // Input fill and drain
    cyc(1, 16'h1111, 0, 0, 16'h0, 0, 0);
    cyc(1, 16'h2222, 0, 0, 16'h0, 0, 0);
    cyc(1, 16'h3333, 0, 0, 16'h0, 0, 0);
    cyc(1, 16'h4444, 0, 0, 16'h0, 0, 0);
    chk("fill_s_ready", {15'd0, s_ready}, 16'h0000);
    chk("fill_in_port", in_port, 16'h1111);
    cyc(1, 16'h5555, 0, 0, 16'h0, 0, 0);
    cyc(0, 16'h0, 1, 0, 16'h0, 0, 0);
    chk("ack_in_port", in_port, 16'h2222);
    chk("ack_s_ready", {15'd0, s_ready}, 16'h0001);
    for (int i = 0; i < 3; i++) cyc(0, 16'h0, 1, 0, 16'h0, 0, 0);
    chk("drain_in_port",  in_port, 16'h0000);
    chk("drain_in_empty", {15'd0, in_empty}, 16'h0001);

    // Underflow and clr_err precedence
    cyc(0, 16'h0, 1, 0, 16'h0, 0, 0);
    chk("udf_set",     {15'd0, udf}, 16'h0001);
    chk("udf_in_port", in_port, 16'h0000);
    cyc(0, 16'h0, 0, 0, 16'h0, 0, 1);
    chk("udf_clr", {15'd0, udf}, 16'h0000);
    cyc(0, 16'h0, 1, 0, 16'h0, 0, 1);
    chk("udf_evt_wins", {15'd0, udf}, 16'h0001);
    cyc(0, 16'h0, 0, 0, 16'h0, 0, 1);

    // Output overflow
    for (int i = 0; i < 4; i++) cyc(0, 16'h0, 0, 1, exp_a[i], 0, 0);
    chk("out_m_valid", {15'd0, m_valid}, 16'h0001);
    chk("out_m_data",  m_data, 16'hA001);
    cyc(0, 16'h0, 0, 1, 16'hA005, 0, 0);
    chk("ovf_set", {15'd0, ovf}, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", m_data, exp_a[i]);
      cyc(0, 16'h0, 0, 0, 16'h0, 1, 0);
    end
    chk("ovf_drain_empty", {15'd0, m_valid}, 16'h0000);
    cyc(0, 16'h0, 0, 0, 16'h0, 0, 1);
    chk("ovf_clr", {15'd0, ovf}, 16'h0000);

    // Full output FIFO with a same-cycle pop accepts the strobe
    for (int i = 0; i < 4; i++) cyc(0, 16'h0, 0, 1, exp_a[i], 0, 0);
    cyc(0, 16'h0, 0, 1, 16'hBEEF, 1, 0);
    chk("fwp_ovf",    {15'd0, ovf}, 16'h0000);
    chk("fwp_m_data", m_data, 16'hA002);
    for (int i = 0; i < 4; i++) begin
      chk("fwp_drain", m_data, exp_b[i]);
      cyc(0, 16'h0, 0, 0, 16'h0, 1, 0);
    end
    chk("fwp_empty", {15'd0, m_valid}, 16'h0000);

    // Random wrap-around stream, 10 words each direction
    in_acc = 0; in_got = 0; out_acc = 0; out_got = 0;
    for (int c = 0; c < 400 && (in_got < 10 || out_got < 10); c++) begin
      logic sv, ia, os, mr;
      sv = (in_acc < 10) && ($urandom_range(0, 1) == 1);
      ia = ($urandom_range(0, 2) != 0) && (in_q.size() != 0);
      mr = ($urandom_range(0, 1) == 1);
      os = (out_acc < 10) && ($urandom_range(0, 1) == 1) && ((out_q.size() < 4) || mr);
      cyc(sv, 16'($urandom), ia, os, 16'($urandom), mr, 0);
    end
    chk("wrap_in_count",  16'(in_got),  16'd10);
    chk("wrap_out_count", 16'(out_got), 16'd10);

    // Mid-operation reset with two words buffered per side and udf set
    cyc(0, 16'h0, 1, 0, 16'h0, 0, 0);
    cyc(1, 16'h5A01, 0, 1, 16'hC001, 0, 0);
    cyc(1, 16'h5A02, 0, 1, 16'hC002, 0, 0);
    rst_cyc(1'b1, 1'b0);
    cyc(0, 16'h0, 0, 0, 16'h0, 0, 0);
    chk("mid_rst_in_empty", {15'd0, in_empty}, 16'h0001);
    chk("mid_rst_m_valid",  {15'd0, m_valid},  16'h0000);
    chk("mid_rst_ovf",      {15'd0, ovf},      16'h0000);
    chk("mid_rst_udf",      {15'd0, udf},      16'h0000);
    chk("mid_rst_s_ready",  {15'd0, s_ready},  16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
